// File: rtl/func_seq_pkg.sv
// Shared constants, state encoding and word-packing helpers for the
// function-processor command sequencer.
package func_seq_pkg;

  // Host command opcodes
  localparam logic [1:0] OP_ARITH   = 2'd0;
  localparam logic [1:0] OP_SORT    = 2'd1;
  localparam logic [1:0] OP_PARITY  = 2'd2;
  localparam logic [1:0] OP_ILLEGAL = 2'd3;

  // Function-processor mode codes
  localparam logic [1:0] MODE_ARITH  = 2'd0;
  localparam logic [1:0] MODE_SORT   = 2'd1;
  localparam logic [1:0] MODE_PARITY = 2'd2;
  localparam logic [1:0] MODE_CLEAR  = 2'd3;

  // Sorter load strobe position inside the processor input word
  localparam int unsigned SORT_EN_BIT = 8;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StClear,
    StLoad,
    StSettle,
    StResp
  } seq_state_e;

  // Arith operands {op, op2, op1} occupy the low 18 bits of the input word.
  function automatic logic [31:0] arith_word(input logic [63:0] arg);
    return {14'd0, arg[17:0]};
  endfunction

  // One sorter load: data byte plus the load strobe.
  function automatic logic [31:0] load_word(input logic [7:0] data);
    logic [31:0] w;
    w = '0;
    w[7:0] = data;
    w[SORT_EN_BIT] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/func_cmd_sequencer.sv
// Initiator for the function-processor register interface: accepts one host
// command, drives mode/input word cycle by cycle, captures both result
// registers after a settle period and returns them on a response handshake.
module func_cmd_sequencer
  import func_seq_pkg::*;
#(
  parameter int unsigned SORT_N = 8,
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [63:0] cmd_arg,
  output logic [1:0]  fp_mode,
  output logic [31:0] fp_in_data,
  input  logic [31:0] fp_reg2,
  input  logic [31:0] fp_reg3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_err
);

  // Terminal counts for the shared 4-bit cycle counter
  localparam logic [3:0] DriveLast  = 4'(SETTLE);
  localparam logic [3:0] SettleLast = 4'(SETTLE - 1);
  localparam logic [3:0] LoadLast   = 4'(SORT_N - 1);

  seq_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] arg_q, arg_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic [1:0]  fp_mode_q, fp_mode_d;
  logic [31:0] fp_in_data_q, fp_in_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [63:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

  logic accept;
  assign accept = cmd_valid && cmd_ready_q;

  // Next-state and registered-output logic for the whole sequence
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    arg_d        = arg_q;
    cmd_ready_d  = cmd_ready_q;
    fp_mode_d    = fp_mode_q;
    fp_in_data_d = fp_in_data_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        // Ready rises one cycle after reset release or after a response.
        cmd_ready_d = 1'b1;
        if (accept) begin
          cmd_ready_d = 1'b0;
          arg_d       = cmd_arg;
          cnt_d       = '0;
          unique case (cmd_op)
            OP_ARITH: begin
              state_d      = StDrive;
              fp_mode_d    = MODE_ARITH;
              fp_in_data_d = arith_word(cmd_arg);
            end
            OP_PARITY: begin
              state_d      = StDrive;
              fp_mode_d    = MODE_PARITY;
              fp_in_data_d = cmd_arg[31:0];
            end
            OP_SORT: begin
              state_d      = StClear;
              fp_mode_d    = MODE_CLEAR;
              fp_in_data_d = '0;
            end
            default: begin
              // Illegal opcode: respond at once, processor left idle.
              state_d     = StResp;
              rsp_valid_d = 1'b1;
              rsp_data_d  = '0;
              rsp_err_d   = 1'b1;
            end
          endcase
        end
      end

      StDrive: begin
        if (cnt_q == DriveLast) begin
          state_d      = StResp;
          rsp_valid_d  = 1'b1;
          rsp_data_d   = {fp_reg3, fp_reg2};
          rsp_err_d    = 1'b0;
          fp_mode_d    = MODE_ARITH;
          fp_in_data_d = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      StClear: begin
        // Bytes are presented LSB first; arg_q is shifted down as they go.
        state_d      = StLoad;
        cnt_d        = '0;
        fp_mode_d    = MODE_SORT;
        fp_in_data_d = load_word(arg_q[7:0]);
        arg_d        = arg_q >> 8;
      end

      StLoad: begin
        if (cnt_q == LoadLast) begin
          state_d      = StSettle;
          cnt_d        = '0;
          fp_in_data_d = '0;
        end else begin
          cnt_d        = cnt_q + 4'd1;
          fp_in_data_d = load_word(arg_q[7:0]);
          arg_d        = arg_q >> 8;
        end
      end

      StSettle: begin
        if (cnt_q == SettleLast) begin
          state_d      = StResp;
          rsp_valid_d  = 1'b1;
          rsp_data_d   = {fp_reg3, fp_reg2};
          rsp_err_d    = 1'b0;
          fp_mode_d    = MODE_ARITH;
          fp_in_data_d = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      StResp: begin
        // rsp_data/rsp_err keep their value after the handshake.
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      default: begin
        state_d     = StIdle;
        cmd_ready_d = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      arg_q        <= '0;
      cmd_ready_q  <= 1'b0;
      fp_mode_q    <= '0;
      fp_in_data_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      arg_q        <= arg_d;
      cmd_ready_q  <= cmd_ready_d;
      fp_mode_q    <= fp_mode_d;
      fp_in_data_q <= fp_in_data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign fp_mode    = fp_mode_q;
  assign fp_in_data = fp_in_data_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_func_cmd_sequencer.sv
// Bench for func_cmd_sequencer: a behavioural function processor answers the
// DUT, and each command is checked cycle by cycle against a schedule and
// response derived from the command itself.
module tb_func_cmd_sequencer;

  localparam int unsigned SETTLE = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [63:0] cmd_arg;
  logic [1:0]  fp_mode;
  logic [31:0] fp_in_data;
  logic [31:0] fp_reg2;
  logic [31:0] fp_reg3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  func_cmd_sequencer #(
    .SORT_N(8),
    .SETTLE(SETTLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .fp_mode   (fp_mode),
    .fp_in_data(fp_in_data),
    .fp_reg2   (fp_reg2),
    .fp_reg3   (fp_reg3),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  // 8-bit ALU: op 0 add, 1 sub (signed overflow flag), 2 and, 3 or.
  function automatic logic [63:0] arith_result(input logic [17:0] w);
    logic [7:0] a, b, r;
    logic       ov;
    a  = w[7:0];
    b  = w[15:8];
    ov = 1'b0;
    case (w[17:16])
      2'd0: begin r = a + b; ov = (a[7] == b[7]) && (r[7] != a[7]); end
      2'd1: begin r = a - b; ov = (a[7] != b[7]) && (r[7] != a[7]); end
      2'd2: r = a & b;
      default: r = a | b;
    endcase
    return {32'd0, 23'd0, ov, r};
  endfunction

  // Ascending sort; reg2 = {s0,s1,s2,s3}, reg3 = {s4,s5,s6,s7}.
  function automatic logic [63:0] sort8(input logic [63:0] v);
    logic [7:0] b [8];
    logic [7:0] t;
    for (int i = 0; i < 8; i++) b[i] = v[8*i +: 8];
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 7 - i; j++)
        if (b[j] > b[j+1]) begin t = b[j]; b[j] = b[j+1]; b[j+1] = t; end
    return {b[4], b[5], b[6], b[7], b[0], b[1], b[2], b[3]};
  endfunction

  function automatic logic [63:0] expect_rsp(input logic [1:0] op, input logic [63:0] arg);
    case (op)
      2'd0:    return arith_result(arg[17:0]);
      2'd1:    return sort8(arg);
      2'd2:    return {63'd0, ^arg[31:0]};
      default: return 64'd0;
    endcase
  endfunction

  // Function-processor model: registers update on each clock from mode/input.
  logic [63:0] sbuf = '0;
  always @(posedge clk) begin : fp_model
    logic [63:0] nbuf;
    nbuf = sbuf;
    if (fp_mode == 2'd3) nbuf = '0;
    else if (fp_in_data[8]) nbuf = {sbuf[55:0], fp_in_data[7:0]};
    sbuf <= nbuf;
    case (fp_mode)
      2'd0:    {fp_reg3, fp_reg2} <= arith_result(fp_in_data[17:0]);
      2'd1:    {fp_reg3, fp_reg2} <= sort8(nbuf);
      2'd2:    {fp_reg3, fp_reg2} <= {63'd0, ^fp_in_data};
      default: {fp_reg3, fp_reg2} <= 64'd0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One command from accept to post-handshake; optionally keeps cmd_valid
  // high presenting the next command while this one is busy.
  task automatic do_cmd(input logic [1:0] op, input logic [63:0] arg, input int hold,
                        input bit keep, input logic [1:0] nop, input logic [63:0] narg);
    logic [1:0]  em [$];
    logic [31:0] ed [$];
    logic [63:0] exp;
    int n, lat;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("ready before accept", 64'(cmd_ready), 64'd1);
    if (n >= 50) return;

    case (op)
      2'd0: for (int i = 0; i < SETTLE + 1; i++) begin em.push_back(2'd0); ed.push_back({14'd0, arg[17:0]}); end
      2'd2: for (int i = 0; i < SETTLE + 1; i++) begin em.push_back(2'd2); ed.push_back(arg[31:0]); end
      2'd1: begin
        em.push_back(2'd3); ed.push_back(32'd0);
        for (int k = 0; k < 8; k++) begin em.push_back(2'd1); ed.push_back(32'h100 | 32'(arg[8*k +: 8])); end
        for (int i = 0; i < SETTLE; i++) begin em.push_back(2'd1); ed.push_back(32'd0); end
      end
      default: ;
    endcase
    lat = em.size() + 1;
    exp = expect_rsp(op, arg);

    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(posedge clk);
    #1;
    if (keep) begin
      cmd_op  = nop;
      cmd_arg = narg;
    end else begin
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_arg   = {$urandom, $urandom};
    end

    for (int c = 1; c < lat; c++) begin
      @(negedge clk);
      check($sformatf("mode op%0d c%0d", op, c), 64'(fp_mode), 64'(em[c-1]));
      check($sformatf("data op%0d c%0d", op, c), 64'(fp_in_data), 64'(ed[c-1]));
      check($sformatf("rsp_valid low c%0d", c), 64'(rsp_valid), 64'd0);
      check($sformatf("busy ready c%0d", c), 64'(cmd_ready), 64'd0);
    end

    @(negedge clk);
    check("rsp_valid at latency", 64'(rsp_valid), 64'd1);
    check("rsp_data", rsp_data, exp);
    check("rsp_err", 64'(rsp_err), 64'(op == 2'd3));
    check("mode idle in resp", 64'(fp_mode), 64'd0);
    check("data idle in resp", 64'(fp_in_data), 64'd0);
    check("ready low in resp", 64'(cmd_ready), 64'd0);

    if (hold > 0) begin
      rsp_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("held rsp_valid", 64'(rsp_valid), 64'd1);
        check("held rsp_data", rsp_data, exp);
        check("held ready low", 64'(cmd_ready), 64'd0);
      end
      rsp_ready = 1'b1;
    end

    @(negedge clk);
    check("rsp_valid after hs", 64'(rsp_valid), 64'd0);
    check("ready after hs", 64'(cmd_ready), 64'd1);
    check("rsp_data kept", rsp_data, exp);
    check("rsp_err kept", 64'(rsp_err), 64'(op == 2'd3));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " cmd_ready"}, 64'(cmd_ready), 64'd0);
    check({tag, " fp_mode"}, 64'(fp_mode), 64'd0);
    check({tag, " fp_in_data"}, 64'(fp_in_data), 64'd0);
    check({tag, " rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, " rsp_data"}, rsp_data, 64'd0);
    check({tag, " rsp_err"}, 64'(rsp_err), 64'd0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [63:0] a;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_arg   = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("in reset");
    rst = 1'b0;
    @(negedge clk);
    check("ready after reset", 64'(cmd_ready), 64'd1);

    // Arith overflow: 100 + 50
    do_cmd(2'd0, 64'h0_3264, 0, 1'b0, 2'd0, 64'd0);
    check("arith ov const", rsp_data, 64'h196);

    // Sort 7,3,9,1,8,2,6,4
    do_cmd(2'd1, 64'h0406_0208_0109_0307, 0, 1'b0, 2'd0, 64'd0);
    check("sort const", rsp_data, 64'h0607_0809_0102_0304);

    // Parity of 7
    do_cmd(2'd2, 64'h7, 0, 1'b0, 2'd0, 64'd0);
    check("parity const", rsp_data, 64'd1);

    // Backpressure, then illegal opcode
    do_cmd(2'd0, {$urandom, $urandom}, 5, 1'b0, 2'd0, 64'd0);
    do_cmd(2'd3, {$urandom, $urandom}, 0, 1'b0, 2'd0, 64'd0);
    check("illegal err const", 64'(rsp_err), 64'd1);
    check("illegal data const", rsp_data, 64'd0);

    // Reset during the fifth LOAD cycle
    a = 64'h1122_3344_5566_7788;
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    cmd_arg   = a;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("load5 data", 64'(fp_in_data), 64'h100 | 64'(a[39:32]));
    rst = 1'b1;
    #1;
    check_all_zero("mid-sort reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready after mid reset", 64'(cmd_ready), 64'd1);
    do_cmd(2'd1, 64'hF0E1_D2C3_B4A5_9687, 0, 1'b0, 2'd0, 64'd0);

    // Back-to-back: sort then arith with cmd_valid held high
    a = {$urandom, $urandom};
    do_cmd(2'd1, {$urandom, $urandom}, 0, 1'b1, 2'd0, a);
    do_cmd(2'd0, a, 0, 1'b0, 2'd0, 64'd0);

    // Randomized commands
    for (int i = 0; i < 40; i++) begin
      do_cmd(2'($urandom), {$urandom, $urandom}, int'($urandom_range(0, 3)), 1'b0, 2'd0, 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
